// File: rtl/sys_ctrl.sv
// sys_ctrl: UART command sequencer driving the register file and ALU, returning results over TX.
// Ports: clk/reset_n; rx_data_in/rx_valid_in (command bytes); tx_data_out/tx_valid_out/tx_ready_in
// (result bytes); rf_* (reg-file write/read pulses, address, data); alu_* (op pulse, function,
// result); busy_out (not IDLE); err_out (bad command, dropped byte or timeout).
module sys_ctrl #(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   rx_data_in,
  input  logic               rx_valid_in,
  output logic [WIDTH-1:0]   tx_data_out,
  output logic               tx_valid_out,
  input  logic               tx_ready_in,
  output logic               rf_wr_en_out,
  output logic               rf_rd_en_out,
  output logic [ADDR-1:0]    rf_addr_out,
  output logic [WIDTH-1:0]   rf_wr_data_out,
  input  logic [WIDTH-1:0]   rf_rd_data_in,
  input  logic               rf_rd_valid_in,
  output logic               alu_en_out,
  output logic [3:0]         alu_fun_out,
  input  logic [2*WIDTH-1:0] alu_result_in,
  input  logic               alu_valid_in,
  output logic               busy_out,
  output logic               err_out
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] CMD_WR = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] CMD_RD = WIDTH'(8'hBB);
  localparam logic [WIDTH-1:0] CMD_OP = WIDTH'(8'hCC);
  localparam logic [WIDTH-1:0] CMD_RUN = WIDTH'(8'hDD);
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, OP_FUN, ALU_WAIT, TX_LO, TX_HI
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic is_alu_q, is_alu_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d, wr_data_q, wr_data_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [3:0] fun_q, fun_d;
  logic tx_valid_q, tx_valid_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic alu_en_q, alu_en_d, busy_q, busy_d, err_q, err_d, tx_acc;
  assign tx_acc = tx_valid_q && tx_ready_in;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    res_d = res_q;
    is_alu_d = is_alu_q;
    tx_data_d = tx_data_q;
    tx_valid_d = 1'b0;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    addr_d = addr_q;
    wr_data_d = wr_data_q;
    alu_en_d = 1'b0;
    fun_d = fun_q;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (rx_valid_in) begin
        state_d = rx_data_in == CMD_WR  ? WR_ADDR :
                  rx_data_in == CMD_RD  ? RD_ADDR :
                  rx_data_in == CMD_OP  ? OP_A    :
                  rx_data_in == CMD_RUN ? OP_FUN  : IDLE;
        err_d = !(rx_data_in inside {CMD_WR, CMD_RD, CMD_OP, CMD_RUN});
      end
      WR_ADDR: if (rx_valid_in) begin
        addr_d = rx_data_in[ADDR-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (rx_valid_in) begin
        wr_data_d = rx_data_in;
        wr_en_d = 1'b1;
        state_d = IDLE;
      end
      RD_ADDR: if (rx_valid_in) begin
        addr_d = rx_data_in[ADDR-1:0];
        rd_en_d = 1'b1;
        cnt_d = '0;
        is_alu_d = 1'b0;
        state_d = RD_WAIT;
      end
      OP_A: if (rx_valid_in) begin
        addr_d = '0;
        wr_data_d = rx_data_in;
        wr_en_d = 1'b1;
        state_d = OP_B;
      end
      OP_B: if (rx_valid_in) begin
        addr_d = ADDR'(1);
        wr_data_d = rx_data_in;
        wr_en_d = 1'b1;
        state_d = OP_FUN;
      end
      OP_FUN: if (rx_valid_in) begin
        fun_d = rx_data_in[3:0];
        alu_en_d = 1'b1;
        cnt_d = '0;
        is_alu_d = 1'b1;
        state_d = ALU_WAIT;
      end
      RD_WAIT, ALU_WAIT: begin
        err_d = rx_valid_in;
        if (state_q == RD_WAIT ? rf_rd_valid_in : alu_valid_in) begin
          res_d = state_q == RD_WAIT ? {{WIDTH{1'b0}}, rf_rd_data_in} : alu_result_in;
          state_d = TX_LO;
        end else if (cnt_q == TLIM) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_LO: begin
        err_d = rx_valid_in;
        // An accepted low byte of an ALU result chains straight into the high byte with no bubble.
        tx_valid_d = !tx_acc || is_alu_q;
        tx_data_d = tx_acc ? res_q[2*WIDTH-1:WIDTH] : res_q[WIDTH-1:0];
        state_d = tx_acc ? (is_alu_q ? TX_HI : IDLE) : TX_LO;
      end
      TX_HI: begin
        err_d = rx_valid_in;
        tx_valid_d = !tx_acc;
        tx_data_d = res_q[2*WIDTH-1:WIDTH];
        state_d = tx_acc ? IDLE : TX_HI;
      end
      default: state_d = IDLE;
    endcase
    fun_d = state_d == IDLE ? 4'd0 : fun_d;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      res_q <= '0;
      is_alu_q <= 1'b0;
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q <= '0;
      wr_data_q <= '0;
      alu_en_q <= 1'b0;
      fun_q <= '0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      is_alu_q <= is_alu_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      addr_q <= addr_d;
      wr_data_q <= wr_data_d;
      alu_en_q <= alu_en_d;
      fun_q <= fun_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  assign tx_data_out = tx_data_q;
  assign tx_valid_out = tx_valid_q;
  assign rf_wr_en_out = wr_en_q;
  assign rf_rd_en_out = rd_en_q;
  assign rf_addr_out = addr_q;
  assign rf_wr_data_out = wr_data_q;
  assign alu_en_out = alu_en_q;
  assign alu_fun_out = fun_q;
  assign busy_out = busy_q;
  assign err_out = err_q;
endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: directed self-checking bench for sys_ctrl with reg-file and ALU responder models.
module tb_sys_ctrl;
  localparam int TIMEOUT = 255;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] rx_data_in = '0, tx_data_out, rf_wr_data_out, rf_rd_data_in;
  logic rx_valid_in = 1'b0, tx_valid_out, tx_ready_in = 1'b0;
  logic rf_wr_en_out, rf_rd_en_out, rf_rd_valid_in, alu_en_out, alu_valid_in, busy_out, err_out;
  logic [3:0] rf_addr_out, alu_fun_out;
  logic [15:0] alu_result_in;
  logic alu_on = 1'b1;
  logic [7:0] regs [16];
  int tests = 0, fails = 0;
  int cyc = 0, wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, err_cnt = 0, tx_cnt = 0;
  int last_wr_cyc = 0, alu_cyc = 0;
  logic [7:0] tx_last = '0, tx_prev = '0;
  logic [3:0] fun_seen = '0;
  logic both_seen = 1'b0;
  sys_ctrl #(.WIDTH(8), .ADDR(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in),
    .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out), .tx_ready_in(tx_ready_in),
    .rf_wr_en_out(rf_wr_en_out), .rf_rd_en_out(rf_rd_en_out), .rf_addr_out(rf_addr_out),
    .rf_wr_data_out(rf_wr_data_out), .rf_rd_data_in(rf_rd_data_in), .rf_rd_valid_in(rf_rd_valid_in),
    .alu_en_out(alu_en_out), .alu_fun_out(alu_fun_out), .alu_result_in(alu_result_in),
    .alu_valid_in(alu_valid_in), .busy_out(busy_out), .err_out(err_out)
  );
  always #5 clk = ~clk;
  // Reg-file returns data one cycle after a read pulse; ALU answers one cycle after its pulse.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_rd_valid_in <= 1'b0;
      rf_rd_data_in <= '0;
      alu_valid_in <= 1'b0;
      alu_result_in <= '0;
    end else begin
      rf_rd_valid_in <= rf_rd_en_out;
      rf_rd_data_in <= regs[rf_addr_out];
      alu_valid_in <= alu_en_out && alu_on;
      alu_result_in <= alu_fun_out == 4'd0 ? 16'(regs[0]) + 16'(regs[1]) : 16'(regs[0]) * 16'(regs[1]);
      if (rf_wr_en_out) regs[rf_addr_out] <= rf_wr_data_out;
    end
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_wr_en_out) begin
      wr_cnt <= wr_cnt + 1;
      last_wr_cyc <= cyc;
    end
    if (rf_rd_en_out) rd_cnt <= rd_cnt + 1;
    if (alu_en_out) begin
      alu_cnt <= alu_cnt + 1;
      alu_cyc <= cyc;
      fun_seen <= alu_fun_out;
    end
    if (err_out) err_cnt <= err_cnt + 1;
    if (tx_valid_out && tx_ready_in) begin
      tx_cnt <= tx_cnt + 1;
      tx_last <= tx_data_out;
      tx_prev <= tx_last;
    end
    if (rf_wr_en_out && rf_rd_en_out) both_seen <= 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  task automatic send(input logic [7:0] b);
    rx_data_in = b;
    rx_valid_in = 1'b1;
    @(negedge clk);
    rx_valid_in = 1'b0;
  endtask
  initial begin
    int b_wr, b_rd, b_alu, b_err, b_tx, n;
    logic stable;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {tx_valid_out, rf_wr_en_out, rf_rd_en_out, alu_en_out, busy_out, err_out}, 0);
    chk("reset_data", {tx_data_out, rf_addr_out, rf_wr_data_out, alu_fun_out}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    b_wr = wr_cnt;
    send(8'hAA); send(8'h05); send(8'h3C);
    chk("wr_pulse", {rf_wr_en_out, rf_rd_en_out, rf_addr_out, rf_wr_data_out}, {1'b1, 1'b0, 4'h5, 8'h3C});
    repeat (3) @(negedge clk);
    chk("wr_once", wr_cnt - b_wr, 1);
    chk("wr_idle", busy_out, 0);
    b_tx = tx_cnt; b_err = err_cnt;
    send(8'hBB); send(8'h05);
    chk("rd_pulse", {rf_rd_en_out, rf_wr_en_out, rf_addr_out}, {1'b1, 1'b0, 4'h5});
    n = 0;
    while (!tx_valid_out && n < 20) begin @(negedge clk); n++; end
    chk("rd_tx_valid", tx_valid_out, 1);
    chk("rd_tx_data", tx_data_out, 8'h3C);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(tx_valid_out === 1'b1 && tx_data_out === 8'h3C)) stable = 1'b0;
    end
    chk("rd_tx_hold", stable, 1);
    send(8'h77);
    chk("drop_err", {err_out, tx_valid_out, tx_data_out}, {1'b1, 1'b1, 8'h3C});
    tx_ready_in = 1'b1;
    @(negedge clk);
    tx_ready_in = 1'b0;
    chk("rd_tx_cnt", tx_cnt - b_tx, 1);
    chk("rd_tx_byte", tx_last, 8'h3C);
    repeat (3) @(negedge clk);
    chk("rd_done", {tx_valid_out, busy_out}, 0);
    chk("rd_err_cnt", err_cnt - b_err, 1);
    b_wr = wr_cnt; b_alu = alu_cnt; b_tx = tx_cnt; b_err = err_cnt;
    tx_ready_in = 1'b1;
    send(8'hCC); send(8'h07); send(8'h09); send(8'h00);
    n = 0;
    while (busy_out && n < 50) begin @(negedge clk); n++; end
    chk("op_finish", busy_out, 0);
    chk("op_wr_cnt", wr_cnt - b_wr, 2);
    chk("op_regs", {regs[0], regs[1]}, {8'h07, 8'h09});
    chk("op_alu_cnt", alu_cnt - b_alu, 1);
    chk("op_fun", fun_seen, 0);
    chk("op_alu_after_wr", alu_cyc > last_wr_cyc, 1);
    chk("op_tx_cnt", tx_cnt - b_tx, 2);
    chk("op_tx_bytes", {tx_prev, tx_last}, 16'h1000);
    chk("op_no_err", err_cnt - b_err, 0);
    tx_ready_in = 1'b0;
    b_wr = wr_cnt; b_rd = rd_cnt; b_alu = alu_cnt; b_tx = tx_cnt;
    send(8'h55);
    chk("bad_err_hi", {err_out, busy_out}, {1'b1, 1'b0});
    @(negedge clk);
    chk("bad_err_lo", err_out, 0);
    chk("bad_no_act", {wr_cnt - b_wr, rd_cnt - b_rd, alu_cnt - b_alu, tx_cnt - b_tx}, 0);
    send(8'hAA); send(8'h0A); send(8'h5A);
    chk("after_bad_wr", {rf_wr_en_out, rf_addr_out, rf_wr_data_out}, {1'b1, 4'hA, 8'h5A});
    alu_on = 1'b0;
    b_alu = alu_cnt; b_tx = tx_cnt; b_err = err_cnt;
    send(8'hDD); send(8'h02);
    n = 0;
    while (!err_out && n < TIMEOUT + 20) begin @(negedge clk); n++; end
    chk("to_window", n >= TIMEOUT - 1 && n <= TIMEOUT + 2, 1);
    @(negedge clk);
    chk("to_idle", {busy_out, err_out, tx_valid_out}, 0);
    chk("to_counts", {alu_cnt - b_alu, tx_cnt - b_tx, err_cnt - b_err}, {32'd1, 32'd0, 32'd1});
    alu_on = 1'b1;
    b_tx = tx_cnt;
    send(8'hDD); send(8'h00);
    n = 0;
    while (!tx_valid_out && n < 30) begin @(negedge clk); n++; end
    chk("hi_lo_byte", {tx_valid_out, tx_data_out}, {1'b1, 8'h10});
    tx_ready_in = 1'b1;
    @(negedge clk);
    tx_ready_in = 1'b0;
    chk("hi_hold", {tx_valid_out, tx_data_out, busy_out}, {1'b1, 8'h00, 1'b1});
    reset_n = 1'b0;
    #1;
    chk("rst_async", {tx_valid_out, tx_data_out, rf_wr_en_out, rf_rd_en_out, alu_en_out, alu_fun_out, busy_out, err_out}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_tx_cnt", tx_cnt - b_tx, 1);
    tx_ready_in = 1'b1;
    b_tx = tx_cnt;
    send(8'hBB); send(8'h00);
    n = 0;
    while (tx_cnt == b_tx && n < 30) begin @(negedge clk); n++; end
    chk("rst_rd_reg0", {tx_cnt - b_tx, 24'd0, tx_last}, {32'd1, 24'd0, 8'h07});
    chk("no_wr_rd_overlap", both_seen, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
